// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type codes, direction codes
// and the router input-port FSM state type.
package noc_pkg;

   localparam int FLIT_W  = 10;
   localparam int COORD_W = 3;
   localparam int NUM_DIR = 5;

   // Flit field bit positions
   localparam int TYPE_HI = 9;
   localparam int TYPE_LO = 8;
   localparam int DX_HI   = 7;
   localparam int DX_LO   = 5;
   localparam int DY_HI   = 4;
   localparam int DY_LO   = 2;

   typedef enum logic [1:0] {
      FT_HEAD      = 2'b00,
      FT_BODY      = 2'b01,
      FT_TAIL      = 2'b10,
      FT_HEAD_TAIL = 2'b11
   } flit_type_e;

   localparam logic [2:0] DIR_N = 3'd0;
   localparam logic [2:0] DIR_S = 3'd1;
   localparam logic [2:0] DIR_E = 3'd2;
   localparam logic [2:0] DIR_W = 3'd3;
   localparam logic [2:0] DIR_L = 3'd4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } ipr_state_e;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY (dimension-ordered) route: X first, then Y, else local.
// Ports: i_dest_x, i_dest_y (destination coords) -> o_dir (direction code).
module xy_route_calc
   import noc_pkg::*;
#(
   parameter int unsigned CUR_X = 0,
   parameter int unsigned CUR_Y = 0
) (
   input  logic [COORD_W-1:0] i_dest_x,
   input  logic [COORD_W-1:0] i_dest_y,
   output logic [2:0]         o_dir
);

   localparam logic [COORD_W-1:0] LX = COORD_W'(CUR_X);
   localparam logic [COORD_W-1:0] LY = COORD_W'(CUR_Y);

   always_comb begin
      if (i_dest_x > LX)
         o_dir = DIR_E;
      else if (i_dest_x < LX)
         o_dir = DIR_W;
      else if (i_dest_y > LY)
         o_dir = DIR_N;
      else if (i_dest_y < LY)
         o_dir = DIR_S;
      else
         o_dir = DIR_L;
   end

endmodule

// File: rtl/input_port_router.sv
// Router input port: one-entry hold register, wormhole route lock (IDLE/PKT)
// and one-hot steering into the five output VC buffers.
// Ports: clk, reset (async high); in_data/in_valid/in_ready link side;
//   out_data/out_write_en/out_full output-buffer side; route_err pulse on a
//   dropped flit; pkt_count completed packets.
// Build option: define IPR_PKT_COUNT_EN to enable pkt_count, else it is 0.
module input_port_router
   import noc_pkg::*;
#(
   parameter int unsigned CUR_X = 0,
   parameter int unsigned CUR_Y = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FLIT_W-1:0] out_data,
   output logic [NUM_DIR-1:0] out_write_en,
   input  logic [NUM_DIR-1:0] out_full,
   output logic              route_err,
   output logic [15:0]       pkt_count
);

   logic [FLIT_W-1:0] r_hold_flit;
   logic              r_hold_valid;
   ipr_state_e        r_state;
   logic [2:0]        r_dir_lock;

   flit_type_e w_type;
   logic       w_is_head;
   logic [2:0] w_route;
   logic [2:0] w_dir;
   logic       w_drop;
   logic       w_fire;
   logic       w_wr;

   xy_route_calc #(
      .CUR_X (CUR_X),
      .CUR_Y (CUR_Y)
   ) u_route (
      .i_dest_x (r_hold_flit[DX_HI:DX_LO]),
      .i_dest_y (r_hold_flit[DY_HI:DY_LO]),
      .o_dir    (w_route)
   );

   assign w_type    = flit_type_e'(r_hold_flit[TYPE_HI:TYPE_LO]);
   assign w_is_head = (w_type == FT_HEAD) || (w_type == FT_HEAD_TAIL);

   // In IDLE only a head may open a packet; in PKT a head is a
   // protocol error and the existing lock is kept.
   always_comb begin
      w_dir  = w_route;
      w_drop = 1'b0;
      if (r_state == ST_PKT) begin
         w_dir  = r_dir_lock;
         w_drop = w_is_head;
      end else begin
         w_drop = !w_is_head;
      end
   end

   // Drops never wait on a full flag.
   assign w_fire = r_hold_valid && (w_drop || !out_full[w_dir]);
   assign w_wr   = w_fire && !w_drop;

   assign in_ready     = !r_hold_valid || w_fire;
   assign out_write_en = w_wr ? (NUM_DIR'(1) << w_dir) : '0;
   assign out_data     = w_wr ? r_hold_flit : '0;
   assign route_err    = w_fire && w_drop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_flit  <= '0;
         r_hold_valid <= 1'b0;
         r_state      <= ST_IDLE;
         r_dir_lock   <= '0;
      end else begin
         if (in_valid && in_ready) begin
            r_hold_flit  <= in_data;
            r_hold_valid <= 1'b1;
         end else if (w_fire) begin
            r_hold_valid <= 1'b0;
         end
         if (w_wr) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_type == FT_HEAD) begin
                     r_dir_lock <= w_dir;
                     r_state    <= ST_PKT;
                  end
               end
               ST_PKT: begin
                  if (w_type == FT_TAIL)
                     r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef IPR_PKT_COUNT_EN
   logic r_unused_pad;
   logic [15:0] r_pkt_count;
   logic        w_is_last;

   assign w_is_last = (w_type == FT_TAIL) || (w_type == FT_HEAD_TAIL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_pkt_count <= '0;
      else if (w_wr && w_is_last)
         r_pkt_count <= r_pkt_count + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_unused_pad <= 1'b0;
      else
         r_unused_pad <= 1'b0;
   end

   assign pkt_count = r_pkt_count;
`else
   assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_input_port_router.sv
// Scoreboard bench for input_port_router at CUR=(2,2): stimulus pushes
// expected writes/errors, a monitor pops and compares on each output.
module tb_input_port_router;
   import noc_pkg::*;

   typedef struct {
      logic       err;
      logic [4:0] en;
      logic [9:0] data;
      logic       b2b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [9:0] out_data;
   logic [4:0] out_write_en;
   logic [4:0] out_full = '0;
   logic       route_err;
   logic [15:0] pkt_count;

   int   n_tests = 0;
   int   n_fail = 0;
   int   exp_pkts = 0;
   int   cyc = 0;
   int   last_wr = -10;
   exp_t q[$];

   always #5 clk = ~clk;

   input_port_router #(
      .CUR_X (2),
      .CUR_Y (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_write_en (out_write_en),
      .out_full     (out_full),
      .route_err    (route_err),
      .pkt_count    (pkt_count)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [9:0] mk_h(input logic [1:0] t,
                                       input int x, input int y);
      return {t, 3'(x), 3'(y), 2'b01};
   endfunction

   function automatic logic [9:0] mk_p(input logic [1:0] t,
                                       input logic [7:0] pl);
      return {t, pl};
   endfunction

   task automatic push_wr(input logic [9:0] f, input int d, input bit b2b);
      exp_t e;
      e.err  = 1'b0;
      e.en   = 5'(1 << d);
      e.data = f;
      e.b2b  = b2b;
      q.push_back(e);
      if (f[9] == 1'b1) exp_pkts++;
   endtask

   task automatic push_err();
      exp_t e;
      e.err  = 1'b1;
      e.en   = '0;
      e.data = '0;
      e.b2b  = 1'b0;
      q.push_back(e);
   endtask

   task automatic send(input logic [9:0] f);
      int t;
      in_data  = f;
      in_valid = 1'b1;
      #1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      check("drain", 32'(q.size()), 0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (!reset) begin
            if (out_write_en != 0 || route_err) begin
               if (q.size() == 0) begin
                  check("unexpected_out", {26'd0, route_err, out_write_en}, 0);
               end else begin
                  e = q.pop_front();
                  check("write_en", 32'(out_write_en), 32'(e.en));
                  check("out_data", 32'(out_data), 32'(e.data));
                  check("route_err", 32'(route_err), 32'(e.err));
                  if (e.b2b) check("b2b_cycle", 32'(cyc), 32'(last_wr + 1));
                  if (!e.err) last_wr = cyc;
               end
            end else begin
               check("idle_data", 32'(out_data), 0);
            end
         end
      end
   end

   initial begin
      logic [9:0] f;
      logic [9:0] g;
      int         xs[6];
      int         ys[6];
      int         ds[6];
      xs = '{2, 2, 0, 2, 7, 0};
      ys = '{2, 6, 2, 0, 7, 7};
      ds = '{4, 0, 3, 1, 2, 3};

      repeat (3) @(negedge clk);
      check("rst_wen", 32'(out_write_en), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_err", 32'(route_err), 0);
      check("rst_cnt", 32'(pkt_count), 0);
      reset = 1'b0;
      #1;
      check("rst_ready", 32'(in_ready), 1);
      @(negedge clk);

      // Back-to-back packet to E
      f = mk_h(2'b00, 5, 1);
      push_wr(f, 2, 1'b0);
      push_wr(mk_p(2'b01, 8'hA5), 2, 1'b1);
      push_wr(mk_p(2'b10, 8'h3C), 2, 1'b1);
      send(f);
      send(mk_p(2'b01, 8'hA5));
      send(mk_p(2'b10, 8'h3C));
      drain();

      // Single-flit packets, routing table
      for (int i = 0; i < 6; i++) begin
         f = mk_h(2'b11, xs[i], ys[i]);
         push_wr(f, ds[i], 1'b0);
         send(f);
      end
      drain();

      // Stall on full E buffer mid-packet
      f = mk_h(2'b00, 6, 2);
      push_wr(f, 2, 1'b0);
      send(f);
      repeat (2) @(negedge clk);
      out_full = 5'b00100;
      g = mk_p(2'b01, 8'h77);
      push_wr(g, 2, 1'b0);
      send(g);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("stall_ready", 32'(in_ready), 0);
         check("stall_wen", 32'(out_write_en), 0);
         @(negedge clk);
      end
      out_full = 5'b11011;
      g = mk_p(2'b10, 8'h11);
      push_wr(g, 2, 1'b0);
      send(g);
      drain();
      out_full = '0;

      // BODY while IDLE, then a normal head
      push_err();
      send(mk_p(2'b01, 8'h55));
      f = mk_h(2'b11, 5, 5);
      push_wr(f, 2, 1'b0);
      send(f);
      drain();

      // Head inside a packet is dropped, lock kept
      f = mk_h(2'b00, 2, 5);
      push_wr(f, 0, 1'b0);
      send(f);
      push_err();
      send(mk_h(2'b00, 0, 0));
      g = mk_p(2'b10, 8'h99);
      push_wr(g, 0, 1'b0);
      send(g);
      drain();
`ifdef IPR_PKT_COUNT_EN
      check("pkt_count", 32'(pkt_count), 32'(exp_pkts));
`else
      check("pkt_count_off", 32'(pkt_count), 0);
`endif

      // Reset mid-packet
      f = mk_h(2'b00, 5, 2);
      push_wr(f, 2, 1'b0);
      send(f);
      g = mk_p(2'b01, 8'h42);
      push_wr(g, 2, 1'b0);
      send(g);
      drain();
      reset = 1'b1;
      exp_pkts = 0;
      @(negedge clk);
      #1;
      check("mid_rst_wen", 32'(out_write_en), 0);
      check("mid_rst_err", 32'(route_err), 0);
      check("mid_rst_cnt", 32'(pkt_count), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", 32'(in_ready), 1);
      @(negedge clk);
      push_err();
      send(mk_p(2'b01, 8'h42));
      f = mk_h(2'b11, 2, 2);
      push_wr(f, 4, 1'b0);
      send(f);
      drain();
`ifdef IPR_PKT_COUNT_EN
      check("pkt_count_end", 32'(pkt_count), 32'(exp_pkts));
`else
      check("pkt_count_end_off", 32'(pkt_count), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
